// File: rtl/dwt_symext_deinterleaver.sv
// rtl/dwt_symext_deinterleaver.sv - raster to {odd,even} pair deinterleaver with whole-sample symmetric extension
// Ping-pong line banks; each line is replayed as 2 mirrored lead-in pairs, P body pairs, 2 mirrored tail pairs.
module dwt_symext_deinterleaver #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 32,
  parameter int OutputReg       = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);
  localparam int Half = MaximumSideSize / 2;
  localparam int AW   = (Half > 1) ? $clog2(Half) : 1;
  localparam int CW   = AW + 1;
  localparam int LW   = AW + 1;

  typedef enum logic [1:0] {IDLE, PRE, BODY, POST} state_t;

  logic [DataWidth-1:0] ram_even [2][Half];
  logic [DataWidth-1:0] ram_odd  [2][Half];

  logic          wr_bank, rd_bank;
  logic [CW-1:0] wr_cnt;
  logic          line_sof;
  logic [1:0]    full;
  logic [1:0]    bank_sof;
  logic [LW-1:0] bank_len [2];

  state_t        state, cur_state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rd_even, rd_odd;
  logic [LW-1:0] plen;
  logic          issue, load_ok, beat_sof, beat_eol, body_last;

  logic                   rd_valid, rd_sof, rd_eol;
  logic [2*DataWidth-1:0] rd_data;

  logic          wr_fire, closing, keep;
  logic [LW-1:0] p_new;

  assign s_ready_o = !rst_i && !full[wr_bank];
  assign wr_fire   = s_valid_i && s_ready_o;
  assign closing   = wr_fire && (s_eol_i || wr_cnt == CW'(MaximumSideSize - 1));
  // Pairs in the closing line: (wr_cnt+1)/2, which drops a trailing odd sample.
  assign p_new     = LW'(wr_cnt[CW-1:1]) + LW'(wr_cnt[0]);
  assign keep      = p_new >= LW'(3);

  // IDLE with a full bank behaves as the first PRE beat so the replay starts without a bubble.
  assign cur_state = (state == IDLE && full[rd_bank]) ? PRE : state;
  assign plen      = bank_len[rd_bank];
  assign body_last = cnt == AW'(plen - LW'(1));
  assign issue     = (cur_state != IDLE) && load_ok;
  assign beat_sof  = (cur_state == PRE) && (cnt == '0) && bank_sof[rd_bank];
  assign beat_eol  = (cur_state == POST) && (cnt != '0);

  always_comb begin
    rd_even = '0;
    rd_odd  = '0;
    case (cur_state)
      PRE: begin
        if (cnt == '0) begin
          rd_even = AW'(2);
          rd_odd  = AW'(1);
        end else begin
          rd_even = AW'(1);
          rd_odd  = '0;
        end
      end
      BODY: begin
        rd_even = cnt;
        rd_odd  = cnt;
      end
      POST: begin
        if (cnt == '0) begin
          rd_even = AW'(plen - LW'(1));
          rd_odd  = AW'(plen - LW'(2));
        end else begin
          rd_even = AW'(plen - LW'(2));
          rd_odd  = AW'(plen - LW'(3));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      if (wr_cnt[0]) ram_odd[wr_bank][wr_cnt[CW-1:1]] <= s_data_i;
      else           ram_even[wr_bank][wr_cnt[CW-1:1]] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_cnt   <= '0;
      line_sof <= 1'b0;
      full     <= '0;
      bank_sof <= '0;
      bank_len <= '{default: '0};
      state    <= IDLE;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_sof   <= 1'b0;
      rd_eol   <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) line_sof <= s_sof_i;
        if (closing) begin
          wr_cnt <= '0;
          // Lines shorter than 6 samples are dropped; the bank stays writable.
          if (keep) begin
            full[wr_bank]     <= 1'b1;
            bank_len[wr_bank] <= p_new;
            bank_sof[wr_bank] <= line_sof;
            wr_bank           <= !wr_bank;
          end
        end else begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end

      if (issue) begin
        case (cur_state)
          PRE: begin
            if (cnt == '0) begin
              state <= PRE;
              cnt   <= AW'(1);
            end else begin
              state <= BODY;
              cnt   <= '0;
            end
          end
          BODY: begin
            if (body_last) begin
              state <= POST;
              cnt   <= '0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
          POST: begin
            if (cnt == '0) begin
              cnt <= AW'(1);
            end else begin
              full[rd_bank] <= 1'b0;
              rd_bank       <= !rd_bank;
              cnt           <= '0;
              state         <= full[!rd_bank] ? PRE : IDLE;
            end
          end
          default: ;
        endcase
      end

      if (load_ok) begin
        rd_valid <= issue;
        rd_sof   <= issue && beat_sof;
        rd_eol   <= issue && beat_eol;
        if (issue) rd_data <= {ram_odd[rd_bank][rd_odd], ram_even[rd_bank][rd_even]};
      end
    end
  end

  generate
    if (OutputReg != 0) begin : g_oreg
      logic                   out_valid, out_sof, out_eol;
      logic [2*DataWidth-1:0] out_data;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          out_valid <= 1'b0;
          out_sof   <= 1'b0;
          out_eol   <= 1'b0;
          out_data  <= '0;
        end else if (!out_valid || m_ready_i) begin
          out_valid <= rd_valid;
          out_sof   <= rd_sof;
          out_eol   <= rd_eol;
          out_data  <= rd_data;
        end
      end

      assign load_ok   = !rd_valid || !out_valid || m_ready_i;
      assign m_valid_o = out_valid;
      assign m_sof_o   = out_sof;
      assign m_eol_o   = out_eol;
      assign m_data_o  = out_data;
    end else begin : g_direct
      assign load_ok   = !rd_valid || m_ready_i;
      assign m_valid_o = rd_valid;
      assign m_sof_o   = rd_sof;
      assign m_eol_o   = rd_eol;
      assign m_data_o  = rd_data;
    end
  endgenerate
endmodule
